// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: the single source of truth for
// the CS state numbering, the opcode header constants and the opcode class vector.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        CS_INSTRUCTION_FETCH = 4'd0,
        CS_REGISTER_FETCH    = 4'd1,
        CS_IMM2              = 4'd2,
        CS_ALU_R3            = 4'd3,
        CS_ALU_RI3           = 4'd4,
        CS_ALU4              = 4'd5,
        CS_BRANCH3           = 4'd6,
        CS_MEM3              = 4'd7,
        CS_LOAD4             = 4'd8,
        CS_STORE4            = 4'd9,
        CS_LOAD5             = 4'd10,
        CS_JUMP3             = 4'd11,
        CS_HALT              = 4'd12
    } csState_e;

    localparam logic [1:0] ALU_R_HEADER      = 2'b00;
    localparam logic [1:0] ALU_RI_HEADER     = 2'b01;
    localparam logic [2:0] MEMORY_REF_HEADER = 3'b100;
    localparam logic [2:0] BRANCH_HEADER     = 3'b101;
    localparam logic [5:0] JUMP_OP           = 6'b110000;
    localparam logic [5:0] IMM_INJECT_OP     = 6'b110001;
    localparam logic [5:0] HALT_OP           = 6'b111111;

    typedef struct packed {
        logic aluR;
        logic aluRi;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic imm;
        logic halt;
        logic illegal;
    } opClass_t;

    // States that wait on the memory handshake and therefore feed the stall counter.
    function automatic logic isMemWaitState(input csState_e s);
        return (s == CS_INSTRUCTION_FETCH) || (s == CS_LOAD4) || (s == CS_STORE4);
    endfunction

endpackage

// File: rtl/control_sequencer_opcode_classifier.sv
// Combinational opcode decoder producing a one-hot instruction class vector.
module opcode_classifier
    import control_sequencer_pkg::*;
(
    input  logic [5:0] opcode,
    output opClass_t   opClass
);

    // Header fields are checked from the widest class down; anything left over is illegal.
    always_comb begin
        opClass = '0;
        if (opcode[5:4] == ALU_R_HEADER) begin
            opClass.aluR = 1'b1;
        end else if (opcode[5:4] == ALU_RI_HEADER) begin
            opClass.aluRi = 1'b1;
        end else if (opcode[5:3] == MEMORY_REF_HEADER) begin
            opClass.load  = ~opcode[2];
            opClass.store = opcode[2];
        end else if (opcode[5:3] == BRANCH_HEADER) begin
            opClass.branch = 1'b1;
        end else if (opcode == JUMP_OP) begin
            opClass.jump = 1'b1;
        end else if (opcode == IMM_INJECT_OP) begin
            opClass.imm = 1'b1;
        end else if (opcode == HALT_OP) begin
            opClass.halt = 1'b1;
        end else begin
            opClass.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control sequencer: steps fetch/decode/execute/memory/writeback states,
// tracks memory stalls, and keeps halt status plus instruction and cycle counters.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int COUNT_W      = 32,
    parameter int MAX_MEM_WAIT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic [3:0]         state,
    output logic               halted,
    output logic               illegal_opcode,
    output logic               mem_timeout,
    output logic [COUNT_W-1:0] instr_count,
    output logic [COUNT_W-1:0] cycle_count
);

    localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);

    csState_e           currentState;
    csState_e           nextState;
    opClass_t           opClass;
    logic [WAIT_W-1:0]  waitCount;
    logic [WAIT_W-1:0]  waitCountNext;
    logic               waitExpired;
    logic               setIllegal;
    logic               setTimeout;
    logic               illegalFlag;
    logic               timeoutFlag;
    logic [COUNT_W-1:0] instrCount;
    logic [COUNT_W-1:0] cycleCount;

    opcode_classifier classifier (
        .opcode  (opcode),
        .opClass (opClass)
    );

    // A ready memory in the same cycle always beats an expired stall budget.
    always_comb begin
        nextState     = currentState;
        setIllegal    = 1'b0;
        setTimeout    = 1'b0;
        waitExpired   = (waitCount == WAIT_W'(MAX_MEM_WAIT)) && !mem_ready;
        waitCountNext = '0;

        case (currentState)
            CS_INSTRUCTION_FETCH: begin
                if (mem_ready) begin
                    nextState = CS_REGISTER_FETCH;
                end else if (waitExpired) begin
                    nextState  = CS_HALT;
                    setTimeout = 1'b1;
                end
            end
            CS_REGISTER_FETCH: begin
                if (opClass.aluR)                       nextState = CS_ALU_R3;
                else if (opClass.aluRi)                 nextState = CS_ALU_RI3;
                else if (opClass.load || opClass.store) nextState = CS_MEM3;
                else if (opClass.branch)                nextState = CS_BRANCH3;
                else if (opClass.jump)                  nextState = CS_JUMP3;
                else if (opClass.imm)                   nextState = CS_IMM2;
                else if (opClass.halt)                  nextState = CS_HALT;
                else begin
                    nextState  = CS_HALT;
                    setIllegal = 1'b1;
                end
            end
            CS_ALU_R3, CS_ALU_RI3: nextState = CS_ALU4;
            CS_ALU4, CS_BRANCH3, CS_JUMP3, CS_IMM2, CS_LOAD5: nextState = CS_INSTRUCTION_FETCH;
            CS_MEM3: nextState = opcode[2] ? CS_STORE4 : CS_LOAD4;
            CS_LOAD4: begin
                if (mem_ready) begin
                    nextState = CS_LOAD5;
                end else if (waitExpired) begin
                    nextState  = CS_HALT;
                    setTimeout = 1'b1;
                end
            end
            CS_STORE4: begin
                if (mem_ready) begin
                    nextState = CS_INSTRUCTION_FETCH;
                end else if (waitExpired) begin
                    nextState  = CS_HALT;
                    setTimeout = 1'b1;
                end
            end
            CS_HALT: nextState = CS_HALT;
            default: nextState = CS_HALT;
        endcase

        if (nextState == currentState && isMemWaitState(currentState) && !mem_ready) begin
            waitCountNext = waitCount + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            currentState <= CS_INSTRUCTION_FETCH;
            waitCount    <= '0;
            illegalFlag  <= 1'b0;
            timeoutFlag  <= 1'b0;
            instrCount   <= '0;
            cycleCount   <= '0;
        end else begin
            currentState <= nextState;
            waitCount    <= waitCountNext;
            if (setIllegal) illegalFlag <= 1'b1;
            if (setTimeout) timeoutFlag <= 1'b1;
            if (currentState == CS_INSTRUCTION_FETCH && nextState == CS_REGISTER_FETCH) begin
                instrCount <= instrCount + 1'b1;
            end
            // The cycle counter sticks at all-ones rather than wrapping.
            if (currentState != CS_HALT && cycleCount != '1) begin
                cycleCount <= cycleCount + 1'b1;
            end
        end
    end

    assign state          = currentState;
    assign halted         = (currentState == CS_HALT);
    assign illegal_opcode = illegalFlag;
    assign mem_timeout    = timeoutFlag;
    assign instr_count    = instrCount;
    assign cycle_count    = cycleCount;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: builds the expected per-cycle state trace of each instruction
// from its class and stall pattern, then replays it against the sequencer.
module tb_control_sequencer;

    localparam int COUNT_W = 32;
    localparam int MAXW    = 4;

    localparam int C_ALUR = 0, C_ALURI = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4;
    localparam int C_JUMP = 5, C_IMM = 6, C_HALT = 7, C_ILLEGAL = 8;

    typedef struct {
        int st;
        bit rdy;
        bit ill;
        bit tmo;
    } step_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [5:0]         opcode;
    logic               mem_ready;
    logic [3:0]         state;
    logic               halted;
    logic               illegal_opcode;
    logic               mem_timeout;
    logic [COUNT_W-1:0] instr_count;
    logic [COUNT_W-1:0] cycle_count;

    int                 checks = 0;
    int                 passes = 0;
    step_t              trace[$];
    bit                 bIll = 1'b0;
    bit                 bTmo = 1'b0;
    logic [COUNT_W-1:0] expInstr = '0;
    logic [COUNT_W-1:0] expCycles = '0;

    control_sequencer #(.COUNT_W(COUNT_W), .MAX_MEM_WAIT(MAXW)) dut (
        .clk            (clk),
        .reset          (reset),
        .opcode         (opcode),
        .mem_ready      (mem_ready),
        .state          (state),
        .halted         (halted),
        .illegal_opcode (illegal_opcode),
        .mem_timeout    (mem_timeout),
        .instr_count    (instr_count),
        .cycle_count    (cycle_count)
    );

    always #5 clk = ~clk;

    function automatic int classOf(input logic [5:0] op);
        if (op[5:4] == 2'b00) return C_ALUR;
        if (op[5:4] == 2'b01) return C_ALURI;
        if (op[5:3] == 3'b100) return op[2] ? C_STORE : C_LOAD;
        if (op[5:3] == 3'b101) return C_BRANCH;
        if (op == 6'b110000) return C_JUMP;
        if (op == 6'b110001) return C_IMM;
        if (op == 6'b111111) return C_HALT;
        return C_ILLEGAL;
    endfunction

    task automatic pushStep(input int st, input bit rdy);
        step_t s;
        s.st  = st;
        s.rdy = rdy;
        s.ill = bIll;
        s.tmo = bTmo;
        trace.push_back(s);
    endtask

    function automatic bit anyReady();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expected trace of one instruction: fetch stalls, decode, then the class-specific tail.
    task automatic buildInstr(input logic [5:0] op, input int ifW, input int memW);
        for (int k = 0; k < ifW; k++) pushStep(0, 1'b0);
        pushStep(0, 1'b1);
        pushStep(1, anyReady());
        case (classOf(op))
            C_ALUR:   begin pushStep(3, anyReady()); pushStep(5, anyReady()); end
            C_ALURI:  begin pushStep(4, anyReady()); pushStep(5, anyReady()); end
            C_BRANCH: pushStep(6, anyReady());
            C_JUMP:   pushStep(11, anyReady());
            C_IMM:    pushStep(2, anyReady());
            C_LOAD: begin
                pushStep(7, anyReady());
                for (int k = 0; k < memW; k++) pushStep(8, 1'b0);
                pushStep(8, 1'b1);
                pushStep(10, anyReady());
            end
            C_STORE: begin
                pushStep(7, anyReady());
                for (int k = 0; k < memW; k++) pushStep(9, 1'b0);
                pushStep(9, 1'b1);
            end
            default: begin
                if (classOf(op) == C_ILLEGAL) bIll = 1'b1;
                for (int k = 0; k < 3; k++) pushStep(12, anyReady());
            end
        endcase
    endtask

    // Replays the trace one cycle per entry, comparing at the negedge before driving mem_ready.
    task automatic applyStimulus(input string tag);
        step_t e;
        int    idx = 0;
        while (trace.size() > 0) begin
            e = trace.pop_front();
            checks += 6;
            if (state !== 4'(e.st))
                $display("[TB] FAIL %s state cyc%0d: got %0d expected %0d", tag, idx, state, e.st);
            else passes++;
            if (halted !== (e.st == 12))
                $display("[TB] FAIL %s halted cyc%0d: got %0d expected %0d", tag, idx, halted, e.st == 12);
            else passes++;
            if (illegal_opcode !== e.ill)
                $display("[TB] FAIL %s illegal cyc%0d: got %0d expected %0d", tag, idx, illegal_opcode, e.ill);
            else passes++;
            if (mem_timeout !== e.tmo)
                $display("[TB] FAIL %s timeout cyc%0d: got %0d expected %0d", tag, idx, mem_timeout, e.tmo);
            else passes++;
            if (instr_count !== expInstr)
                $display("[TB] FAIL %s instr_count cyc%0d: got %0d expected %0d", tag, idx, instr_count, expInstr);
            else passes++;
            if (cycle_count !== expCycles)
                $display("[TB] FAIL %s cycle_count cyc%0d: got %0d expected %0d", tag, idx, cycle_count, expCycles);
            else passes++;
            mem_ready = e.rdy;
            if (e.st == 0 && e.rdy) expInstr = expInstr + 1'b1;
            if (e.st != 12 && expCycles != '1) expCycles = expCycles + 1'b1;
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic doReset();
        reset     = 1'b1;
        mem_ready = anyReady();
        @(negedge clk);
        reset     = 1'b0;
        expInstr  = '0;
        expCycles = '0;
        bIll      = 1'b0;
        bTmo      = 1'b0;
    endtask

    task automatic runInstr(input string tag, input logic [5:0] op, input int ifW, input int memW);
        opcode = op;
        buildInstr(op, ifW, memW);
        applyStimulus(tag);
    endtask

    task automatic test_reset();
        checks += 4;
        if (state !== 4'd0) $display("[TB] FAIL reset_state: got %0d expected 0", state);
        else passes++;
        if ({halted, illegal_opcode, mem_timeout} !== 3'b000)
            $display("[TB] FAIL reset_flags: got %b expected 000", {halted, illegal_opcode, mem_timeout});
        else passes++;
        if (instr_count !== '0) $display("[TB] FAIL reset_instr: got %0d expected 0", instr_count);
        else passes++;
        if (cycle_count !== '0) $display("[TB] FAIL reset_cycle: got %0d expected 0", cycle_count);
        else passes++;
    endtask

    task automatic test_directed();
        runInstr("alu_r", 6'b000010, 0, 0);
        runInstr("alu_ri", 6'b011101, 1, 0);
        runInstr("load", 6'b100000, 0, 3);
        runInstr("store", 6'b100100, 0, 0);
        runInstr("branch", 6'b101011, 0, 0);
        runInstr("jump", 6'b110000, 0, 0);
        runInstr("imm", 6'b110001, 0, 0);
        runInstr("store_wait", 6'b100111, 2, MAXW);
    endtask

    task automatic test_illegal();
        logic [COUNT_W-1:0] frozen;
        runInstr("illegal", 6'b110111, 0, 0);
        frozen = expCycles;
        repeat (3) @(negedge clk);
        checks += 2;
        if (illegal_opcode !== 1'b1) $display("[TB] FAIL illegal_sticky: got %0d expected 1", illegal_opcode);
        else passes++;
        if (cycle_count !== frozen) $display("[TB] FAIL halt_cycle_frozen: got %0d expected %0d", cycle_count, frozen);
        else passes++;
        doReset();
        test_reset();
        runInstr("halt_op", 6'b111111, 0, 0);
        doReset();
    endtask

    task automatic test_timeout();
        opcode = 6'b000001;
        for (int k = 0; k <= MAXW; k++) pushStep(0, 1'b0);
        bTmo = 1'b1;
        for (int k = 0; k < 3; k++) pushStep(12, anyReady());
        applyStimulus("timeout_if");
        doReset();
        opcode = 6'b100010;
        pushStep(0, 1'b1);
        pushStep(1, anyReady());
        pushStep(7, anyReady());
        for (int k = 0; k <= MAXW; k++) pushStep(8, 1'b0);
        bTmo = 1'b1;
        for (int k = 0; k < 3; k++) pushStep(12, anyReady());
        applyStimulus("timeout_load");
        doReset();
    endtask

    task automatic test_reset_mid_load();
        opcode = 6'b100001;
        pushStep(0, 1'b1);
        pushStep(1, anyReady());
        pushStep(7, anyReady());
        pushStep(8, 1'b0);
        pushStep(8, 1'b0);
        applyStimulus("mid_load");
        checks++;
        if (state !== 4'd8) $display("[TB] FAIL mid_load_state: got %0d expected 8", state);
        else passes++;
        doReset();
        test_reset();
    endtask

    task automatic test_counter_limits();
        force dut.instrCount = '1;
        #1 release dut.instrCount;
        expInstr = '1;
        runInstr("instr_wrap", 6'b101000, 0, 0);
        checks++;
        if (instr_count !== '0) $display("[TB] FAIL instr_wrap_end: got %0d expected 0", instr_count);
        else passes++;
        force dut.cycleCount = '1;
        #1 release dut.cycleCount;
        expCycles = '1;
        runInstr("cycle_sat", 6'b100000, 1, 2);
        checks++;
        if (cycle_count !== '1) $display("[TB] FAIL cycle_sat_end: got %0h expected all-ones", cycle_count);
        else passes++;
        doReset();
    endtask

    task automatic test_random();
        logic [5:0] op;
        int         cls;
        for (int n = 0; n < 40; n++) begin
            op  = 6'($urandom_range(0, 63));
            cls = classOf(op);
            runInstr("random", op, $urandom_range(0, MAXW), $urandom_range(0, MAXW));
            if (cls == C_HALT || cls == C_ILLEGAL) doReset();
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_directed();
        test_illegal();
        test_timeout();
        test_reset_mid_load();
        test_counter_limits();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
